// File: rtl/rib_arbiter.sv
// Three-master fixed-priority bus arbiter in front of a single slave port.
// Grants are non-pre-emptive and bounded by a slave-ack timeout.
//
// state | meaning
// IDLE  | no owner; slave port quiet; winner picked at next edge
// BUSY  | owner routed to slave; waiting for ack, abort or timeout
module rib_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  input  logic        m2_req_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_addr_i,
  input  logic [31:0] m2_wdata_i,
  output logic [31:0] m2_rdata_o,
  output logic        m2_ack_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ack_i,
  output logic        hold_flag_o,
  output logic        err_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        own_req;
  logic        own_we;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [1:0]  winner;
  logic        any_req;
  logic        timeout_hit;
  logic        own_ack;
  logic [31:0] own_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = 32'd0;
    own_wdata = 32'd0;
    case (owner_q)
      2'd0: begin
        own_req   = m0_req_i;
        own_we    = m0_we_i;
        own_addr  = m0_addr_i;
        own_wdata = m0_wdata_i;
      end
      2'd1: begin
        own_req   = m1_req_i;
        own_we    = m1_we_i;
        own_addr  = m1_addr_i;
        own_wdata = m1_wdata_i;
      end
      2'd2: begin
        own_req   = m2_req_i;
        own_we    = m2_we_i;
        own_addr  = m2_addr_i;
        own_wdata = m2_wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    any_req = m0_req_i | m1_req_i | m2_req_i;
    winner  = 2'd2;
    if (m0_req_i)      winner = 2'd0;
    else if (m1_req_i) winner = 2'd1;
  end

  // A dropped request (abort) suppresses the timeout; a slave ack overrides both.
  assign timeout_hit = (state_q == BUSY) & ~s_ack_i & own_req & (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          owner_d = winner;
          cnt_d   = 8'd0;
        end
      end
      BUSY: begin
        if (s_ack_i || !own_req || timeout_hit) begin
          state_d = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = 32'd0;
    s_wdata_o  = 32'd0;
    err_o      = 1'b0;
    own_ack    = 1'b0;
    own_rdata  = 32'd0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m2_ack_o   = 1'b0;
    m0_rdata_o = 32'd0;
    m1_rdata_o = 32'd0;
    m2_rdata_o = 32'd0;
    if (state_q == BUSY) begin
      s_req_o   = 1'b1;
      s_we_o    = own_we;
      s_addr_o  = own_addr;
      s_wdata_o = own_wdata;
      err_o     = timeout_hit;
      own_ack   = s_ack_i | timeout_hit;
      own_rdata = s_ack_i ? s_rdata_i : 32'd0;
      case (owner_q)
        2'd0: begin
          m0_ack_o   = own_ack;
          m0_rdata_o = own_rdata;
        end
        2'd1: begin
          m1_ack_o   = own_ack;
          m1_rdata_o = own_rdata;
        end
        2'd2: begin
          m2_ack_o   = own_ack;
          m2_rdata_o = own_rdata;
        end
        default: ;
      endcase
    end
  end

  // Fetch stall; gated by reset so every output is quiet while rst is low.
  assign hold_flag_o = rst & (m0_req_i | m1_req_i) & m2_req_i & ~m2_ack_o;

endmodule

// File: doc/rib_arbiter.md
RIB_ARBITER -- requirements
Module: rib_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, max BUSY cycles without slave ack before forced completion; legal range 2..255.
REQ-002 SHALL have ports: clk  input  1  single clock for all state; rising edge.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: m{0,1,2}_req_i  input  1  master request (m0 = load/store data path, m1 = debug, m2 = instruction fetch).
REQ-005 SHALL have ports: m{0,1,2}_we_i  input  1  master write enable.
REQ-006 SHALL have ports: m{0,1,2}_addr_i  input  32  master address.
REQ-007 SHALL have ports: m{0,1,2}_wdata_i  input  32  master write data.
REQ-008 SHALL have ports: m{0,1,2}_rdata_o  output  32  read data returned to master.
REQ-009 SHALL have ports: m{0,1,2}_ack_o  output  1  one-cycle completion pulse to master.
REQ-010 SHALL have ports: s_req_o / s_we_o  output  1 / 1  slave request and write enable.
REQ-011 SHALL have ports: s_addr_o / s_wdata_o  output  32 / 32  slave address and write data.
REQ-012 SHALL have ports: s_rdata_i  input  32  slave read data.
REQ-013 SHALL have ports: s_ack_i  input  1  slave completion, valid in the cycle it is high.
REQ-014 SHALL have ports: hold_flag_o  output  1  pipeline stall request.
REQ-015 SHALL have ports: err_o  output  1  one-cycle timeout pulse.

Function
REQ-016 SHALL implement FSM with states IDLE and BUSY, plus a 2-bit owner register and a timeout counter.
REQ-017 In IDLE, SHALL select a winner by fixed priority m0 > m1 > m2 among asserted req_i.
REQ-018 At the IDLE clock edge with any request, SHALL load owner and enter BUSY; no request means it stays in IDLE.
REQ-019 In IDLE, SHALL drive s_req_o, s_we_o, s_addr_o and s_wdata_o to 0, and all ack_o and rdata_o to 0.
REQ-020 In BUSY, SHALL drive s_req_o=1 and route s_we_o/s_addr_o/s_wdata_o combinationally from the owner's inputs.
REQ-021 In BUSY, SHALL drive owner ack_o = s_ack_i and owner rdata_o = s_rdata_i (zero when s_ack_i=0); non-owners read 0.
REQ-022 SHALL return from BUSY to IDLE at the edge where s_ack_i=1; minimum transaction is 2 cycles and at least one IDLE cycle separates grants.
REQ-023 A requester SHALL not be pre-empted; a higher-priority request arriving in BUSY waits for the next IDLE.
REQ-024 If the owner drops req_i while BUSY and s_ack_i=0, SHALL abort: return to IDLE next edge, no ack, no err.
REQ-025 If s_ack_i=1 and the owner drops req_i in the same cycle, ack SHALL win and the transaction completes normally.
REQ-026 Timeout counter SHALL clear on entering BUSY and increment each BUSY cycle with s_ack_i=0.
REQ-027 When the counter equals TIMEOUT_CYCLES-1 with s_ack_i=0, SHALL pulse err_o=1 and owner ack_o=1 with rdata_o=0 for that cycle, then return to IDLE.
REQ-028 Counter SHALL saturate, never wrap, and s_ack_i in the timeout cycle SHALL take priority (normal ack, no err).
REQ-029 hold_flag_o SHALL be (m0_req_i | m1_req_i) & m2_req_i & ~m2_ack_o, i.e. fetch is blocked by a competing master; otherwise 0.
REQ-030 Outputs in BUSY SHALL be glitch-free functions of registered state and current inputs; no combinational path SHALL run from s_ack_i to s_req_o.

Reset
REQ-031 On rst=0, SHALL immediately (asynchronously) force state IDLE, owner=0 and counter=0, and set all outputs to 0, including mid-transaction.
REQ-032 After rst release, the first grant SHALL occur no earlier than the first rising edge with rst=1 and req pending.

Verification
REQ-033 Single read: m2 req addr 0x100, slave acks 2 cycles later with 0xDEADBEEF -> s_addr_o=0x100, m2_ack_o for one cycle, m2_rdata_o=0xDEADBEEF, FSM back to IDLE.
REQ-034 Contention: m0 write (0x200, 0x12345678) and m2 read requested in the same cycle -> m0 granted first, hold_flag_o=1 throughout, m2 granted after m0 ack plus one IDLE cycle.
REQ-035 Timeout: TIMEOUT_CYCLES=4, m1 req, s_ack_i held 0 -> err_o and m1_ack_o high in the 4th BUSY cycle, m1_rdata_o=0, then IDLE.
REQ-036 Abort: m0 granted, m0_req_i dropped before ack -> IDLE next edge, no m0_ack_o, no err_o; a subsequent m2 request is granted normally.
REQ-037 Reset mid-BUSY: assert rst=0 between edges during an m0 write -> s_req_o=0 and s_we_o=0 immediately; after release, FSM is IDLE and counter is 0.
REQ-038 Priority order: m1 and m2 requesting simultaneously, then m0 added while m1 is BUSY -> grant order m1, m0, m2.
